// File: rtl/ma_pkg.sv
// Shared types and default widths for the memory-access issue queue.
package ma_pkg;

  localparam int MA_DEPTH          = 4;
  localparam int MA_TAG_WIDTH      = 4;
  localparam int MA_ARF_ADDRWIDTH  = 5;
  localparam int MA_ARF_DATAWIDTH  = 36;
  localparam int MA_VRF_ADDRWIDTH  = 10;
  localparam int MA_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    WAIT_LINK = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } ma_iq_state_t;

  // Canonical field order of a queued instruction at the default widths.
  // The queue packs its entries in this same order (tag in the MSBs,
  // offset in the LSBs) for any parameterisation.
  typedef struct packed {
    logic [MA_TAG_WIDTH-1:0]     tag;
    logic                        sel_v_m;
    logic                        ld_st;
    logic [MA_VRF_ADDRWIDTH-1:0] v_m_reg;
    logic [MA_ARF_ADDRWIDTH-1:0] a_reg;
    logic [MA_ARF_DATAWIDTH-1:0] offset;
  } ma_instr_t;

  function automatic int instr_width(input int tag_w, input int vrf_w,
                                     input int arf_a_w, input int arf_d_w);
    return tag_w + 2 + vrf_w + arf_a_w + arf_d_w;
  endfunction

endpackage

// File: rtl/ma_issue_queue_if.sv
// Decode-side instruction channel, controller channel and completion
// channel of the memory-access issue queue.
//
// Handshakes:
//   in_*  : one instruction transfers on each rising clk edge where
//           in_valid_i and in_ready_o are both 1; in_ready_o depends only
//           on registered occupancy, never on in_valid_i.
//   ma_*  : ma_start_o is a one-cycle pulse; the field outputs are stable
//           from that pulse until ma_done_i (a one-cycle pulse) is seen.
//   cpl_* : cpl_valid_o is a one-cycle pulse, cpl_tag_o holds otherwise.
// The queue uses the master modport, the decode/controller side the slave.
interface ma_issue_queue_if
  import ma_pkg::*;
#(
  parameter int TAG_WIDTH     = MA_TAG_WIDTH,
  parameter int ARF_ADDRWIDTH = MA_ARF_ADDRWIDTH,
  parameter int ARF_DATAWIDTH = MA_ARF_DATAWIDTH,
  parameter int VRF_ADDRWIDTH = MA_VRF_ADDRWIDTH
) ();

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic                     in_sel_v_m_i;
  logic                     in_ld_st_i;
  logic [VRF_ADDRWIDTH-1:0] in_v_m_reg_i;
  logic [ARF_ADDRWIDTH-1:0] in_a_reg_i;
  logic [ARF_DATAWIDTH-1:0] in_offset_i;
  logic [TAG_WIDTH-1:0]     in_tag_i;

  logic                     ma_start_o;
  logic                     ma_select_v_m_o;
  logic                     ma_v_load_or_store_o;
  logic [VRF_ADDRWIDTH-1:0] ma_v_m_reg_o;
  logic [ARF_ADDRWIDTH-1:0] ma_a_reg_o;
  logic [ARF_DATAWIDTH-1:0] ma_a_offset_o;
  logic                     ma_done_i;

  logic                     cpl_valid_o;
  logic [TAG_WIDTH-1:0]     cpl_tag_o;

  modport master (
    input  in_valid_i, in_sel_v_m_i, in_ld_st_i, in_v_m_reg_i, in_a_reg_i,
           in_offset_i, in_tag_i, ma_done_i,
    output in_ready_o, ma_start_o, ma_select_v_m_o, ma_v_load_or_store_o,
           ma_v_m_reg_o, ma_a_reg_o, ma_a_offset_o, cpl_valid_o, cpl_tag_o
  );

  modport slave (
    output in_valid_i, in_sel_v_m_i, in_ld_st_i, in_v_m_reg_i, in_a_reg_i,
           in_offset_i, in_tag_i, ma_done_i,
    input  in_ready_o, ma_start_o, ma_select_v_m_o, ma_v_load_or_store_o,
           ma_v_m_reg_o, ma_a_reg_o, ma_a_offset_o, cpl_valid_o, cpl_tag_o
  );

endinterface

// File: rtl/ma_sync_fifo.sv
// Synchronous FIFO with a full flush and a flush that keeps only the head
// entry (used while the head instruction is in flight).
module ma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  input  logic             flush_keep_head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Flushes win over push/pop; pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else if (flush_keep_head) begin
      if (count != '0) begin
        wr_ptr <= rd_ptr + AW'(1);
        count  <= CW'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write; entries carry no reset since occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (push && !flush && !flush_keep_head) mem[wr_ptr] <= push_data;
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ma_issue_queue.sv
// Memory-access issue queue: buffers decoded MA instructions and issues
// them one at a time to ma_controller via ma_start/ma_done, returning one
// tagged completion per instruction.
// Optional watchdog: define MA_ISSUE_TIMEOUT_EN to add timeout_o.
module ma_issue_queue
  import ma_pkg::*;
#(
  parameter int DEPTH         = MA_DEPTH,
  parameter int TAG_WIDTH     = MA_TAG_WIDTH,
  parameter int ARF_ADDRWIDTH = MA_ARF_ADDRWIDTH,
  parameter int ARF_DATAWIDTH = MA_ARF_DATAWIDTH,
  parameter int VRF_ADDRWIDTH = MA_VRF_ADDRWIDTH
`ifdef MA_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = MA_TIMEOUT_CYCLES
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ma_ddr4_linkup_i,
  input  logic                   flush_i,
  ma_issue_queue_if.master       bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o,
  output ma_iq_state_t           state_o
`ifdef MA_ISSUE_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  localparam int W        = instr_width(TAG_WIDTH, VRF_ADDRWIDTH,
                                        ARF_ADDRWIDTH, ARF_DATAWIDTH);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int OFF_LSB  = 0;
  localparam int AREG_LSB = OFF_LSB + ARF_DATAWIDTH;
  localparam int VREG_LSB = AREG_LSB + ARF_ADDRWIDTH;
  localparam int LDST_BIT = VREG_LSB + VRF_ADDRWIDTH;
  localparam int SEL_BIT  = LDST_BIT + 1;
  localparam int TAG_LSB  = SEL_BIT + 1;

  ma_iq_state_t state, state_next;

  logic [W-1:0]  push_data, head_data;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, flush_all, flush_keep, load_fields;

  logic                     sel_q, ldst_q;
  logic [VRF_ADDRWIDTH-1:0] vreg_q;
  logic [ARF_ADDRWIDTH-1:0] areg_q;
  logic [ARF_DATAWIDTH-1:0] off_q;
  logic                     cpl_valid_q;
  logic [TAG_WIDTH-1:0]     cpl_tag_q;

  assign push_data = {bus.in_tag_i, bus.in_sel_v_m_i, bus.in_ld_st_i,
                      bus.in_v_m_reg_i, bus.in_a_reg_i, bus.in_offset_i};

  // A flush in the same cycle always discards the incoming instruction.
  assign push = bus.in_valid_i & ~full & ~flush_i;

  ma_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .push_data       (push_data),
    .pop             (pop),
    .flush           (flush_all),
    .flush_keep_head (flush_keep),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .head_data       (head_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LINK;
    else        state <= state_next;
  end

  // Next state plus FIFO control. The head stays queued while in flight,
  // so a flush during ISSUE/WAIT_DONE keeps it unless it completes now.
  always_comb begin
    state_next  = state;
    load_fields = 1'b0;
    pop         = 1'b0;
    flush_all   = 1'b0;
    flush_keep  = 1'b0;
    case (state)
      WAIT_LINK: begin
        flush_all = flush_i;
        if (ma_ddr4_linkup_i) state_next = IDLE;
      end
      IDLE: begin
        if (flush_i) begin
          flush_all = 1'b1;
        end else if (!empty) begin
          state_next  = ISSUE;
          load_fields = 1'b1;
        end
      end
      ISSUE: begin
        flush_keep = flush_i;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.ma_done_i) begin
          pop        = 1'b1;
          flush_all  = flush_i;
          state_next = IDLE;
        end else begin
          flush_keep = flush_i;
        end
      end
      default: state_next = WAIT_LINK;
    endcase
  end

  // Controller fields are captured only when an instruction is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      ldst_q <= 1'b0;
      vreg_q <= '0;
      areg_q <= '0;
      off_q  <= '0;
    end else if (load_fields) begin
      sel_q  <= head_data[SEL_BIT];
      ldst_q <= head_data[LDST_BIT];
      vreg_q <= head_data[VREG_LSB +: VRF_ADDRWIDTH];
      areg_q <= head_data[AREG_LSB +: ARF_ADDRWIDTH];
      off_q  <= head_data[OFF_LSB +: ARF_DATAWIDTH];
    end
  end

  // One completion pulse per popped head; the tag holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
    end else begin
      cpl_valid_q <= pop;
      if (pop) cpl_tag_q <= head_data[TAG_LSB +: TAG_WIDTH];
    end
  end

`ifdef MA_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Watchdog: restarts on entry to WAIT_DONE, flags a long wait or a done
  // pulse arriving when nothing is awaited. The flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (state == WAIT_DONE) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
        else                                      wd_cnt    <= wd_cnt + WD_W'(1);
      end
      if (bus.ma_done_i && (state != WAIT_DONE)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`endif

  assign bus.in_ready_o           = ~full;
  assign bus.ma_start_o           = (state == ISSUE);
  assign bus.ma_select_v_m_o      = sel_q;
  assign bus.ma_v_load_or_store_o = ldst_q;
  assign bus.ma_v_m_reg_o         = vreg_q;
  assign bus.ma_a_reg_o           = areg_q;
  assign bus.ma_a_offset_o        = off_q;
  assign bus.cpl_valid_o          = cpl_valid_q;
  assign bus.cpl_tag_o            = cpl_tag_q;

  assign count_o = count;
  assign busy_o  = (state == ISSUE) || (state == WAIT_DONE);
  assign state_o = state;

endmodule

// File: tb/tb_ma_issue_queue.sv
// Bench for ma_issue_queue: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a queue-based model of the queue.
module tb_ma_issue_queue;
  import ma_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int AAW   = 5;
  localparam int ADW   = 36;
  localparam int VAW   = 10;
  localparam int W     = TW + 2 + VAW + AAW + ADW;
  localparam int FW    = W - TW;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic linkup = 1'b0;
  logic flush  = 1'b0;
  always #5 clk = ~clk;

  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  ma_iq_state_t           state;
`ifdef MA_ISSUE_TIMEOUT_EN
  logic                   timeout;
`endif

  ma_issue_queue_if bus ();

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign bus.ma_done_i = resp_done | spur_done;

  ma_issue_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ma_ddr4_linkup_i (linkup),
    .flush_i          (flush),
    .bus              (bus.master),
    .count_o          (count),
    .busy_o           (busy),
    .state_o          (state)
`ifdef MA_ISSUE_TIMEOUT_EN
    ,
    .timeout_o        (timeout)
`endif
  );
`ifdef MA_ISSUE_TIMEOUT_EN
  defparam dut.TIMEOUT_CYCLES = 16;
`endif

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  // ---------------- controller responder ----------------
  int resp_cnt   = -1;
  int resp_delay = 2;
  bit auto_en    = 1'b1;

  always @(negedge clk) begin
    resp_done = 1'b0;
    if (!rst_n) begin
      resp_cnt = -1;
    end else begin
      if (resp_cnt == 0) begin
        resp_done = 1'b1;
        resp_cnt  = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end
      if (bus.ma_start_o && auto_en) resp_cnt = resp_delay;
    end
  end

  // ---------------- reference model ----------------
  // exp_q holds every accepted instruction not yet completed (head first).
  // m_phase: 0 = nothing in flight, 1 = start cycle, 2 = awaiting done.
  logic [W-1:0]  exp_q[$];
  bit            m_linked;
  int            m_phase;
  logic          e_start, e_cplv;
  logic [TW-1:0] e_tag;
  logic [FW-1:0] e_fields;

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] head;
    bit           do_push;
    if (!rst_n) begin
      exp_q.delete();
      m_linked = 1'b0;
      m_phase  = 0;
      e_start  = 1'b0;
      e_cplv   = 1'b0;
      e_tag    = '0;
      e_fields = '0;
    end else begin
      do_push = bus.in_valid_i && (exp_q.size() < DEPTH) && !flush;
      e_start = 1'b0;
      e_cplv  = 1'b0;
      if (!m_linked) begin
        if (linkup) m_linked = 1'b1;
        if (flush) exp_q.delete();
      end else if (m_phase == 0) begin
        if (flush) begin
          exp_q.delete();
        end else if (exp_q.size() > 0) begin
          head     = exp_q[0];
          m_phase  = 1;
          e_start  = 1'b1;
          e_fields = head[FW-1:0];
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        if (flush) while (exp_q.size() > 1) exp_q.pop_back();
      end else begin
        if (bus.ma_done_i) begin
          head   = exp_q.pop_front();
          e_cplv = 1'b1;
          e_tag  = head[W-1:FW];
          if (flush) exp_q.delete();
          m_phase = 0;
        end else if (flush) begin
          while (exp_q.size() > 1) exp_q.pop_back();
        end
      end
      if (do_push)
        exp_q.push_back({bus.in_tag_i, bus.in_sel_v_m_i, bus.in_ld_st_i,
                         bus.in_v_m_reg_i, bus.in_a_reg_i, bus.in_offset_i});
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int            start_cnt = 0;
  int            cpl_cnt   = 0;
  logic [TW-1:0] cpl_log[$];

  always @(negedge clk) begin : scoreboard
    ma_iq_state_t e_state;
    if (rst_n) begin
      e_state = !m_linked ? WAIT_LINK : (m_phase == 0) ? IDLE :
                (m_phase == 1) ? ISSUE : WAIT_DONE;
      check("in_ready", 64'(bus.in_ready_o), 64'(exp_q.size() < DEPTH));
      check("count", 64'(count), 64'(exp_q.size()));
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("state", 64'(state), 64'(e_state));
      check("ma_start", 64'(bus.ma_start_o), 64'(e_start));
      check("cpl_valid", 64'(bus.cpl_valid_o), 64'(e_cplv));
      check("cpl_tag", 64'(bus.cpl_tag_o), 64'(e_tag));
      check("fields", 64'({bus.ma_select_v_m_o, bus.ma_v_load_or_store_o,
                           bus.ma_v_m_reg_o, bus.ma_a_reg_o,
                           bus.ma_a_offset_o}), 64'(e_fields));
      if (bus.ma_start_o) start_cnt++;
      if (bus.cpl_valid_o) begin
        cpl_cnt++;
        cpl_log.push_back(bus.cpl_tag_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_instr(input logic [TW-1:0] tag, input logic sel,
                           input logic ld, input logic [VAW-1:0] vreg,
                           input logic [AAW-1:0] areg, input logic [ADW-1:0] off);
    bus.in_tag_i     = tag;
    bus.in_sel_v_m_i = sel;
    bus.in_ld_st_i   = ld;
    bus.in_v_m_reg_i = vreg;
    bus.in_a_reg_i   = areg;
    bus.in_offset_i  = off;
  endtask

  task automatic push_wait(input logic [TW-1:0] tag, input logic sel,
                           input logic ld, input logic [VAW-1:0] vreg,
                           input logic [AAW-1:0] areg, input logic [ADW-1:0] off);
    int n;
    set_instr(tag, sel, ld, vreg, areg, off);
    bus.in_valid_i = 1'b1;
    n = 0;
    while (!bus.in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic push_rand(input logic [TW-1:0] tag);
    push_wait(tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              VAW'($urandom()), AAW'($urandom()),
              ADW'({$urandom(), $urandom()}));
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!bus.ma_start_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_start", 64'(bus.ma_start_o), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((count != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 64'(n < bound), 64'd1);
    idle(2);
  endtask

  task automatic pulse_spur();
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, s0, c0;
    bus.in_valid_i = 1'b0;
    set_instr('0, 1'b0, 1'b0, '0, '0, '0);

    // Reset with the link down.
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ma_start", 64'(bus.ma_start_o), 64'd0);
    check("rst_cpl_valid", 64'(bus.cpl_valid_o), 64'd0);
    check("rst_state", 64'(state), 64'(WAIT_LINK));
`ifdef MA_ISSUE_TIMEOUT_EN
    check("rst_timeout", 64'(timeout), 64'd0);
`endif

    // Push before link-up: nothing issues until the link comes up.
    resp_delay = 3;
    push_wait(4'd5, 1'b0, 1'b0, 10'd7, 5'd3, 36'h000001000);
    idle(5);
    check("t1_no_start", 64'(start_cnt), 64'd0);
    check("t1_count", 64'(count), 64'd1);
    linkup = 1'b1;
    wait_start(n);
    check("t1_latency", 64'(n), 64'd2);
    check("t1_offset", 64'(bus.ma_a_offset_o), 64'h000001000);
    check("t1_a_reg", 64'(bus.ma_a_reg_o), 64'd3);
    wait_idle(100);

    // Spurious done while idle.
    c0 = cpl_cnt;
`ifdef MA_ISSUE_TIMEOUT_EN
    check("t5_timeout_before", 64'(timeout), 64'd0);
`endif
    pulse_spur();
    idle(3);
    check("t5_no_cpl", 64'(cpl_cnt - c0), 64'd0);
    check("t5_count", 64'(count), 64'd0);
`ifdef MA_ISSUE_TIMEOUT_EN
    check("t5_timeout_after", 64'(timeout), 64'd1);
`endif

    // Fill to DEPTH, hold a fifth push, completions in order.
    resp_delay = 20;
    cpl_log.delete();
    for (int i = 0; i < 4; i++) push_rand(TW'(i));
    check("t2_full_ready", 64'(bus.in_ready_o), 64'd0);
    check("t2_full_count", 64'(count), 64'd4);
    push_rand(4'd4);
    wait_idle(500);
    check("t2_cpl_num", 64'(cpl_log.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < cpl_log.size()) check("t2_cpl_order", 64'(cpl_log[i]), 64'(i));

    // Long controller delay: one start, fields held (model checks each cycle).
    resp_delay = 50;
    s0 = start_cnt;
    push_rand(4'd6);
    wait_idle(200);
    check("t3_one_start", 64'(start_cnt - s0), 64'd1);

    // Flush plus push with three queued and the head in flight.
    resp_delay = 10;
    s0 = start_cnt;
    c0 = cpl_cnt;
    push_rand(4'd8);
    push_rand(4'd9);
    push_rand(4'd10);
    check("t4_pre_count", 64'(count), 64'd3);
    check("t4_pre_busy", 64'(busy), 64'd1);
    set_instr(4'd11, 1'b1, 1'b0, 10'd1, 5'd1, 36'h1);
    bus.in_valid_i = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    flush = 1'b0;
    check("t4_after_flush_count", 64'(count), 64'd1);
    wait_idle(200);
    idle(15);
    check("t4_starts", 64'(start_cnt - s0), 64'd1);
    check("t4_cpls", 64'(cpl_cnt - c0), 64'd1);
    check("t4_cpl_tag", 64'(bus.cpl_tag_o), 64'd8);
    check("t4_count", 64'(count), 64'd0);

    // Reset in the middle of an operation.
    resp_delay = 8;
    push_rand(4'd1);
    push_rand(4'd2);
    idle(3);
    do_reset();
    c0 = cpl_cnt;
    s0 = start_cnt;
    idle(20);
    check("mrst_no_cpl", 64'(cpl_cnt - c0), 64'd0);
    check("mrst_no_start", 64'(start_cnt - s0), 64'd0);
    check("mrst_count", 64'(count), 64'd0);

    // Randomized traffic with occasional flush and stray done pulses.
    for (int c = 0; c < 800; c++) begin
      bus.in_valid_i = 1'($urandom_range(0, 1));
      set_instr(TW'($urandom()), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), VAW'($urandom()), AAW'($urandom()),
                ADW'({$urandom(), $urandom()}));
      flush      = ($urandom_range(0, 15) == 0);
      spur_done  = ($urandom_range(0, 40) == 0);
      resp_delay = $urandom_range(0, 6);
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    flush          = 1'b0;
    spur_done      = 1'b0;
    resp_delay     = 2;
    wait_idle(500);

`ifdef MA_ISSUE_TIMEOUT_EN
    // Withheld done: the watchdog fires, a late done still completes.
    do_reset();
    auto_en = 1'b0;
    push_rand(4'd12);
    wait_start(n);
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout_delay", 64'(n), 64'd17);
    c0 = cpl_cnt;
    pulse_spur();
    idle(3);
    check("t6_late_cpl", 64'(cpl_cnt - c0), 64'd1);
    check("t6_timeout_sticky", 64'(timeout), 64'd1);
    auto_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
